seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, greater than BLANK_CYCLES.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: anti-ghosting off-time at the start of each slot, at least 1.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have: value  input  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
REQ-007 SHALL have: load  input  1  single-cycle strobe requesting capture of value and dp_mask.
REQ-008 SHALL have: dp_mask  input  NUM_DIGITS  bit i set lights the decimal point of digit i.
REQ-009 SHALL have: lz_en  input  1  enables leading-zero suppression; sampled every cycle.
REQ-010 SHALL have: num  output  4  nibble driven into the seven-segment decoder.
REQ-011 SHALL have: an_n  output  NUM_DIGITS  active-low digit enables; at most one bit low.
REQ-012 SHALL have: dp_n  output  1  active-low decimal point for the enabled digit.
REQ-013 SHALL have: load_ack  output  1  one-cycle pulse when a pending load is committed.

Function
REQ-014 SHALL implement a two-state FSM, BLANK then SHOW, with a slot counter cnt (0..REFRESH_DIV-1) and a digit index idx (0..NUM_DIGITS-1).
REQ-015 SHALL, in BLANK, drive an_n all ones and dp_n 1; after cnt reaches BLANK_CYCLES-1, SHALL enter SHOW.
REQ-016 SHALL, in SHOW, drive an_n low at bit idx only, unless idx is suppressed (REQ-020).
REQ-017 SHALL, at cnt == REFRESH_DIV-1, reset cnt to 0, enter BLANK, and advance idx, wrapping from NUM_DIGITS-1 to 0.
REQ-018 SHALL register all outputs; num, an_n and dp_n reflect the current idx/state in the same cycle the state register holds it.
REQ-019 SHALL drive num from the shadow nibble of idx during both BLANK and SHOW, and drive dp_n = ~shadow_dp[idx] during SHOW.
REQ-020 SHALL, when lz_en=1, suppress digit idx (an_n stays all ones, dp_n=1) if idx>0 and that shadow nibble and all higher shadow nibbles are zero; digit 0 is never suppressed.
REQ-021 SHALL, on load, store value/dp_mask in a pending register and set pending; a second load before commit SHALL overwrite the pending data, and only one ack SHALL follow.
REQ-022 SHALL commit pending data into the shadow, clear pending, and pulse load_ack in the cycle idx wraps to 0; a display never mixes two loads within one frame.
REQ-023 SHALL, when load coincides with the commit cycle, commit the previously pending data and keep the new data pending for the next frame.
REQ-024 SHALL, when no data is pending at the wrap, leave the shadow unchanged and keep load_ack 0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state=BLANK, cnt=0, idx=0, shadow=0, shadow_dp=0, pending=0, num=0, an_n all ones, dp_n=1, load_ack=0; rst overrides load, including mid-SHOW.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; cycle k = k-th edge after rst release)
REQ-026 SHALL check the scan: rst release -> an_n=1111 at k0-1, 1110 at k2-7, 1111 at k8-9, 1101 at k10-15, ..., 0111 at k26-31, back to 1110 at k34.
REQ-027 SHALL check a mid-frame load: load with value=0x1234 and dp_mask=0010 at k5 -> num stays 0 until k32; at k32 load_ack=1 for one cycle; num=4 at k32; during k42-47, an_n=1101, num=3, dp_n=0.
REQ-028 SHALL check overwrite: loads of 0x1111 at k3 and 0x2222 at k20 -> a single load_ack at k32, and all digits show 2.
REQ-029 SHALL check suppression: value=0x0045 committed, lz_en=1 -> digits 2 and 3 keep an_n=1111 through their SHOW; lz_en=1 with value 0x0000 -> digit 0 shows num=0, an_n=1110.
REQ-030 SHALL check reset mid-operation: rst at k12 during SHOW of digit 1 with data pending -> next cycle all REQ-025 values, no load_ack, and the scan restarts per REQ-026.
REQ-031 SHALL check a coincident load: load of 0xAAAA at k32 with 0x5555 pending -> 0x5555 is committed at k32 and 0xAAAA at k64, with exactly one ack each.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-slot blanking, leading-zero
// suppression and frame-synchronous double-buffered loading of the displayed value.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    dp_n,
    output logic                    load_ack
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [3:0]              num_q, num_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    load_ack_q, load_ack_d;

    logic                    frame_wrap;
    logic                    zero_run;
    logic                    suppress;
    logic                    lit;

    // Scan sequencing: blank window, then show until the slot ends.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        frame_wrap = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IDX_LAST) begin
                idx_d      = '0;
                frame_wrap = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
            state_d = SHOW;
        end
    end

    // Commit happens before a same-cycle load is accepted, so the new data waits a frame.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        load_ack_d  = 1'b0;
        if (frame_wrap && pend_q) begin
            shadow_d    = pend_val_q;
            shadow_dp_d = pend_dp_q;
            pend_d      = 1'b0;
            load_ack_d  = 1'b1;
        end
        if (load) begin
            pend_d     = 1'b1;
            pend_val_d = value;
            pend_dp_d  = dp_mask;
        end
    end

    // A digit is dark when it and every digit to its left hold zero.
    always_comb begin
        zero_run = 1'b1;
        suppress = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (shadow_d[4*i +: 4] == 4'd0);
            if (lz_en && zero_run && (idx_d == IDX_W'(i))) begin
                suppress = 1'b1;
            end
        end
    end

    always_comb begin
        lit    = (state_d == SHOW) && !suppress;
        num_d  = shadow_d[{idx_d, 2'b00} +: 4];
        an_n_d = '1;
        dp_n_d = 1'b1;
        if (lit) begin
            an_n_d = ~(NUM_DIGITS'(1) << idx_d);
            dp_n_d = ~shadow_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= 1'b0;
            pend_val_q  <= '0;
            pend_dp_q   <= '0;
            num_q       <= '0;
            an_n_q      <= '1;
            dp_n_q      <= 1'b1;
            load_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_q      <= pend_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            num_q       <= num_d;
            an_n_q      <= an_n_d;
            dp_n_q      <= dp_n_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign num      = num_q;
    assign an_n     = an_n_q;
    assign dp_n     = dp_n_q;
    assign load_ack = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scan/load/suppression/reset scenarios plus a
// randomized run, all checked every cycle against a frame-arithmetic reference model.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  num;
    logic [3:0]  an_n;
    logic        dp_n;
    logic        load_ack;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value   (value),
        .load    (load),
        .dp_mask (dp_mask),
        .lz_en   (lz_en),
        .num     (num),
        .an_n    (an_n),
        .dp_n    (dp_n),
        .load_ack(load_ack)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;
    int ack_seen = 0;

    // Reference model: time since reset, displayed data, pending buffer.
    int          t = 0;
    logic [15:0] m_sh = '0;
    logic [3:0]  m_dp = '0;
    bit          m_pend = 0;
    logic [15:0] m_pv = '0;
    logic [3:0]  m_pdp = '0;
    bit          m_ack = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic step();
        int         idx;
        int         cnt;
        bit         show;
        bit         supp;
        logic [3:0] e_num;
        logic [3:0] e_an;
        logic       e_dp;
        @(posedge clk);
        if (rst) begin
            t = 0; m_sh = '0; m_dp = '0; m_pend = 0; m_ack = 0;
        end else begin
            t++;
            m_ack = 0;
            if ((t % FRAME) == 0 && m_pend) begin
                m_sh = m_pv; m_dp = m_pdp; m_pend = 0; m_ack = 1;
            end
            if (load) begin
                m_pend = 1; m_pv = value; m_pdp = dp_mask;
            end
        end
        k    = t;
        idx  = (t / RD) % N;
        cnt  = t % RD;
        show = (cnt >= BC);
        supp = lz_en && (idx > 0) && ((m_sh >> (4 * idx)) == 16'd0);
        e_num = 4'((m_sh >> (4 * idx)) & 16'hF);
        e_an  = (show && !supp) ? ~(4'b0001 << idx) : 4'hF;
        e_dp  = (show && !supp) ? ~m_dp[idx] : 1'b1;
        #1;
        check_eq("num", num, e_num);
        check_eq("an_n", an_n, e_an);
        check_eq("dp_n", dp_n, e_dp);
        check_eq("load_ack", load_ack, m_ack);
        $display("k=%0d rst=%0b load=%0b val=%04h lz=%0b -> num=%0h an_n=%04b dp_n=%0b ack=%0b",
                 k, rst, load, value, lz_en, num, an_n, dp_n, load_ack);
        if (load_ack) ack_seen++;
        load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ack_seen = 0;
    endtask

    task automatic run_to(input int kk);
        while (k < kk) step();
    endtask

    task automatic load_at(input int kk, input logic [15:0] v, input logic [3:0] d);
        run_to(kk - 1);
        value   = v;
        dp_mask = d;
        load    = 1'b1;
        step();
    endtask

    int         scan_k[10]   = '{1, 2, 7, 8, 9, 10, 15, 26, 31, 34};
    logic [3:0] scan_an[10]  = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'h7, 4'h7, 4'hE};

    initial begin
        // Basic scan from reset.
        do_reset();
        check_eq("rst_an_n", an_n, 4'hF);
        check_eq("rst_num", num, 4'h0);
        for (int i = 0; i < 10; i++) begin
            run_to(scan_k[i]);
            check_eq("scan_an_n", an_n, scan_an[i]);
        end

        // Mid-frame load committed at the frame wrap.
        do_reset();
        load_at(5, 16'h1234, 4'b0010);
        run_to(31);
        check_eq("mid_num_pre", num, 4'h0);
        run_to(32);
        check_eq("mid_ack", load_ack, 1'b1);
        check_eq("mid_num", num, 4'h4);
        run_to(33);
        check_eq("mid_ack_off", load_ack, 1'b0);
        run_to(44);
        check_eq("mid_an_n", an_n, 4'hD);
        check_eq("mid_num3", num, 4'h3);
        check_eq("mid_dp_n", dp_n, 1'b0);
        check_eq("mid_ack_cnt", ack_seen, 1);

        // Overwrite of pending data yields one ack.
        do_reset();
        load_at(3, 16'h1111, 4'h0);
        load_at(20, 16'h2222, 4'h0);
        run_to(32);
        check_eq("ovw_ack", load_ack, 1'b1);
        run_to(42);
        check_eq("ovw_num1", num, 4'h2);
        run_to(58);
        check_eq("ovw_num3", num, 4'h2);
        run_to(63);
        check_eq("ovw_ack_cnt", ack_seen, 1);

        // Leading-zero suppression.
        do_reset();
        lz_en = 1'b1;
        load_at(1, 16'h0045, 4'h0);
        run_to(42);
        check_eq("lz_an_d1", an_n, 4'hD);
        run_to(50);
        check_eq("lz_an_d2", an_n, 4'hF);
        run_to(58);
        check_eq("lz_an_d3", an_n, 4'hF);
        load_at(70, 16'h0000, 4'h0);
        run_to(98);
        check_eq("lz_zero_an", an_n, 4'hE);
        check_eq("lz_zero_num", num, 4'h0);
        run_to(106);
        check_eq("lz_zero_d1", an_n, 4'hF);
        lz_en = 1'b0;

        // Reset during SHOW of digit 1 with data pending.
        do_reset();
        load_at(5, 16'h9876, 4'hF);
        run_to(11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mrst_num", num, 4'h0);
        check_eq("mrst_an_n", an_n, 4'hF);
        check_eq("mrst_dp_n", dp_n, 1'b1);
        check_eq("mrst_ack", load_ack, 1'b0);
        ack_seen = 0;
        run_to(2);
        check_eq("mrst_scan", an_n, 4'hE);
        run_to(40);
        check_eq("mrst_no_ack", ack_seen, 0);

        // Load coinciding with the commit cycle.
        do_reset();
        load_at(5, 16'h5555, 4'h0);
        load_at(32, 16'hAAAA, 4'h0);
        check_eq("coin_ack1", load_ack, 1'b1);
        check_eq("coin_num1", num, 4'h5);
        run_to(42);
        check_eq("coin_hold", num, 4'h5);
        run_to(64);
        check_eq("coin_ack2", load_ack, 1'b1);
        check_eq("coin_num2", num, 4'hA);
        run_to(70);
        check_eq("coin_ack_cnt", ack_seen, 2);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst     = (($urandom % 400) == 0);
            load    = (($urandom % 8) == 0);
            value   = 16'($urandom) >> (4 * ($urandom % 4));
            dp_mask = 4'($urandom);
            if (($urandom % 16) == 0) lz_en = ~lz_en;
            step();
        end
        rst  = 1'b0;
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
